// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory backend between the CPU port and a host port
// Optional feature macro: MEM_ARB_TIMEOUT_EN enables the backend wait timeout.
module mem_arbiter #(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                i_cpu_op,
    input  logic [ADDR_WIDTH-1:0]     i_cpu_addr,
    input  logic [DATA_BUS_WIDTH-1:0] i_cpu_wdata,
    output logic [DATA_BUS_WIDTH-1:0] o_cpu_rdata,
    output logic                      o_cpu_done,
    input  logic                      i_host_req,
    input  logic                      i_host_we,
    input  logic [ADDR_WIDTH-1:0]     i_host_addr,
    input  logic [DATA_BUS_WIDTH-1:0] i_host_wdata,
    output logic [DATA_BUS_WIDTH-1:0] o_host_rdata,
    output logic                      o_host_ack,
    output logic                      o_be_start,
    output logic                      o_be_we,
    output logic [ADDR_WIDTH-1:0]     o_be_addr,
    output logic [DATA_BUS_WIDTH-1:0] o_be_wdata,
    input  logic [DATA_BUS_WIDTH-1:0] i_be_rdata,
    input  logic                      i_be_done,
    output logic                      o_grant_host,
    output logic                      o_timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_e                    r_state, w_next;
    logic [SW-1:0]             r_starve;
    logic                      w_cpu_req, w_any_req, w_pick_host, w_timeout, w_finish, w_grant;
    logic [DATA_BUS_WIDTH-1:0] w_rd;

    // Opcode 3 is a NOP, so only READ and WRITE count as a CPU request.
    assign w_cpu_req   = (i_cpu_op == 2'd1) || (i_cpu_op == 2'd2);
    assign w_any_req   = w_cpu_req || i_host_req;
    assign w_pick_host = i_host_req && (!w_cpu_req || r_starve == SW'(STARVE_LIMIT));
    assign w_grant     = (r_state == IDLE) && w_any_req;
    assign w_finish    = (r_state == WAIT) && (i_be_done || w_timeout);
    assign w_rd        = i_be_done ? i_be_rdata : '1;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wait_cnt;
    // A real be_done in the expiry cycle takes precedence over the timeout.
    assign w_timeout = (r_state == WAIT) && !i_be_done && (r_wait_cnt == TW'(TIMEOUT_CYCLES));
    // Count WAIT cycles from zero on entry and latch a sticky error on expiry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_cnt    <= '0;
            o_timeout_err <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + TW'(1) : '0;
            if (w_timeout) o_timeout_err <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign o_timeout_err    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: one backend transaction per grant.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any_req ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = w_finish ? RESP : WAIT;
            default: w_next = IDLE;
        endcase
    end

    // Registered outputs: command latch, pulses, read-data capture and starvation count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_be_start   <= 1'b0;
            o_cpu_done   <= 1'b0;
            o_host_ack   <= 1'b0;
            o_grant_host <= 1'b0;
            o_be_we      <= 1'b0;
            o_be_addr    <= '0;
            o_be_wdata   <= '0;
            o_cpu_rdata  <= '0;
            o_host_rdata <= '0;
            r_starve     <= '0;
        end else begin
            o_be_start <= w_grant;
            o_cpu_done <= w_finish && !o_grant_host;
            o_host_ack <= w_finish && o_grant_host;
            if (w_grant) begin
                o_grant_host <= w_pick_host;
                o_be_we      <= w_pick_host ? i_host_we : (i_cpu_op == 2'd2);
                o_be_addr    <= w_pick_host ? i_host_addr : i_cpu_addr;
                o_be_wdata   <= w_pick_host ? i_host_wdata : i_cpu_wdata;
            end else if (r_state == RESP) begin
                o_grant_host <= 1'b0;
            end
            if (w_finish && !o_be_we && o_grant_host) o_host_rdata <= w_rd;
            if (w_finish && !o_be_we && !o_grant_host) o_cpu_rdata <= w_rd;
            if (((r_state == IDLE) && !i_host_req) || ((r_state == RESP) && o_grant_host))
                r_starve <= '0;
            else if ((r_state == RESP) && i_host_req && (r_starve != SW'(STARVE_LIMIT)))
                r_starve <= r_starve + SW'(1);
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide memory backend (SPI RAM/flash engine) between the CPU controller's memory port and an external host/loader port. It accepts level-held requests, grants one owner at a time with CPU priority and starvation protection for the host, and runs one backend transaction per grant. It returns a one-cycle completion pulse to the granted requester. It sits between `ctrl`/address mux and the memory engine and drives the `mem_op_done` seen by `ctrl`.

## Interface
- `DATA_BUS_WIDTH`, 8: data width.
- `ADDR_WIDTH`, 8: address width.
- `STARVE_LIMIT`, 4: consecutive CPU grants allowed while `host_req` is pending.
- `TIMEOUT_CYCLES`, 64: backend wait limit. Used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clock` in 1: clock, rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `cpu_op` in 2: `mem_ctrl_op_e`. MEM_NOP=0, MEM_READ=1, MEM_WRITE=2; value 3 is treated as NOP.
- `cpu_addr` in ADDR_WIDTH: CPU address (selected PC/MAR).
- `cpu_wdata` in DATA_BUS_WIDTH: CPU write data.
- `cpu_rdata` out DATA_BUS_WIDTH: read data returned to the CPU.
- `cpu_done` out 1: one-cycle completion pulse to the CPU (`mem_op_done`).
- `host_req` in 1: host request, held high until `host_ack`.
- `host_we` in 1: 1 = host write, 0 = host read.
- `host_addr` in ADDR_WIDTH, `host_wdata` in DATA_BUS_WIDTH: host address and write data.
- `host_rdata` out DATA_BUS_WIDTH: read data returned to the host.
- `host_ack` out 1: one-cycle completion pulse to the host.
- `be_start` out 1: one-cycle backend start pulse.
- `be_we` out 1, `be_addr` out ADDR_WIDTH, `be_wdata` out DATA_BUS_WIDTH: backend command, held stable from `be_start` until `be_done`.
- `be_rdata` in DATA_BUS_WIDTH: backend read data, valid with `be_done`.
- `be_done` in 1: one-cycle backend completion pulse.
- `grant_host` out 1: 1 while the current transaction is owned by the host.
- `timeout_err` out 1: sticky backend-timeout flag.

## Operation
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** samples requests; the CPU is requesting when `cpu_op` is READ or WRITE.
  - CPU only: grant CPU.
  - Host only: grant host.
  - Both: grant CPU unless `starve_cnt == STARVE_LIMIT`, in which case grant host.
  - On grant: latch owner into `grant_host`, `be_we`, `be_addr` and `be_wdata`, then go to ISSUE.
  - Neither requesting: stay in IDLE.
- **ISSUE:** `be_start` = 1 for exactly one cycle, then go to WAIT.
- **WAIT:** on `be_done`, capture `be_rdata` into the owner's rdata register (reads only), then go to RESP.
  - Writes leave both rdata registers unchanged.
- **RESP:** pulse `cpu_done` or `host_ack` (owner only) for one cycle, update `starve_cnt`, then go to IDLE.
- `starve_cnt` update rules:
  - Increments, saturating at `STARVE_LIMIT`, on each CPU grant completed while `host_req` = 1.
  - Clears on a host grant or whenever `host_req` = 0 in IDLE.
- `cpu_rdata` and `host_rdata` hold their last captured value until their next read capture.
- Requester rule: after seeing done/ack, a requester presents its next op (or NOP/req low) by the following cycle. The arbiter ignores requests during RESP.
  - Back-to-back CPU READs with `cpu_op` never dropping are therefore legal, and each one is a distinct transaction.
- `be_done` outside WAIT is ignored.
- Request inputs are not re-sampled between IDLE and RESP. Changes to them mid-transaction do not affect the in-flight command.

## Timing
- Request visible in IDLE at cycle T:
  - `be_start` is high in cycle T+1.
  - `be_done` arrives at cycle D ≥ T+2.
  - done/ack is high in D+1.
  - Next IDLE sample is at D+2.
- Minimum request-to-done latency: 3 cycles.
- Minimum issue rate: 1 transaction per 4 cycles.
- Reset mid-operation returns the FSM to IDLE immediately and clears all outputs and `starve_cnt`. No done/ack is issued for the aborted transaction.
- `be_done` asserted together with reset deassertion is ignored.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A WAIT cycle counter, sized to hold `TIMEOUT_CYCLES`, is cleared on entering WAIT.
  - When it reaches `TIMEOUT_CYCLES` without `be_done`, go to RESP with the owner's rdata forced to all ones (reads only) and set `timeout_err` sticky until reset.
  - `be_done` in the same cycle as expiry wins, and no error is flagged.
- `MEM_ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT lasts until `be_done`.
  - `timeout_err` is tied to 0.
  - The `TIMEOUT_CYCLES` parameter is ignored.

## Test plan
- CPU READ at addr 0x12, backend returns 0xA5 two cycles after `be_start` -> `be_addr`=0x12, `be_we`=0, `cpu_rdata`=0xA5 with `cpu_done` one cycle, `host_ack` stays 0.
- Host write 0x3C to 0x40 while CPU idle -> `grant_host`=1, `be_we`=1, `be_wdata`=0x3C, `host_ack` one pulse, `cpu_rdata` unchanged.
- CPU and host request simultaneously, CPU reissues READ continuously, `STARVE_LIMIT`=4 -> four CPU grants, then host granted on the fifth, then CPU again.
- CPU holds `cpu_op`=READ across two transactions (0x00 then 0x01) -> two `be_start` pulses, two `cpu_done` pulses, no missed or merged transaction.
- Reset asserted in WAIT, then stray `be_done` after release -> no done/ack, FSM in IDLE, all outputs 0.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, backend never responds to a CPU read -> `cpu_done` pulse 8 cycles after entering WAIT plus 1, `cpu_rdata`=0xFF, `timeout_err`=1 until reset.
